// File: rtl/riscv_multicycle_core_pkg.sv
// Shared constants and types for the multi-cycle RV32I/RV32E core:
// opcode and function-field encodings, FSM states, ALU operations
// and halt-cause codes.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    HALT_NONE     = 2'd0,
    HALT_ILLEGAL  = 2'd1,
    HALT_MISALIGN = 2'd2,
    HALT_ECALL    = 2'd3
  } halt_cause_e;

endpackage

// File: rtl/riscv_multicycle_core_if.sv
// Shared instruction/data memory port with a valid/ready handshake.
interface riscv_multicycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/riscv_multicycle_core_regfile.sv
// Architectural register file: two asynchronous read ports, one
// synchronous write port, x0 hardwired to zero, asynchronous clear.
module mc_regfile #(
  parameter int unsigned REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  output logic [31:0] rd1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  localparam int AW = $clog2(REG_COUNT);

  logic [31:0] regs_q [REG_COUNT];

  // Out-of-range indices read as zero so RV32E never reads past the array.
  assign rd1 = (ra1 != 5'd0 && 32'(ra1) < REG_COUNT) ? regs_q[ra1[AW-1:0]] : 32'h0;
  assign rd2 = (ra2 != 5'd0 && 32'(ra2) < REG_COUNT) ? regs_q[ra2[AW-1:0]] : 32'h0;

  // Register writes; x0 and out-of-range targets are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we && wa != 5'd0 && 32'(wa) < REG_COUNT) begin
      regs_q[wa[AW-1:0]] <= wd;
    end
  end

endmodule

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I/RV32E core sequenced FETCH -> DECODE -> EXEC ->
// (MEM) -> (WB) over a single shared memory port. Any fault parks the
// core in HALT with a cause code until reset.
module riscv_multicycle_core
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  riscv_multicycle_core_if.master         mem,
  output logic                            retire,
  output logic                            halted,
  output logic [1:0]                      halt_cause,
  output logic [31:0]                     debug_pc,
  output logic [31:0]                     debug_inst
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        halted_q, halted_d;
  halt_cause_e cause_q, cause_d;

  logic        halt_req;
  halt_cause_e halt_code;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, rs1_val, rs2_val;
  logic        legal, uses_rs1, uses_rs2, uses_rd, is_sys, reg_bad;
  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_res, addr_sum, pc_plus4, pc_imm, jalr_tgt;
  logic        br_taken;

  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  function automatic logic [31:0] alu_f(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, sa < sb};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return sa >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic br_f(logic [2:0] fn, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (fn)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return sa < sb;
      F3_BGE:  return sa >= sb;
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  mc_regfile #(.REG_COUNT(REG_COUNT)) u_rf (
    .clk   (clk),
    .rst_n (reset),
    .ra1   (rs1),
    .rd1   (rs1_val),
    .ra2   (rs2),
    .rd2   (rs2_val),
    .we    (state_q == ST_WB && uses_rd),
    .wa    (rd),
    .wd    (wb_data_q)
  );

  // Immediate generation by instruction format.
  always_comb begin
    case (opc)
      OPC_LUI, OPC_AUIPC: imm = {ir_q[31:12], 12'b0};
      OPC_JAL:            imm = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      OPC_BRANCH:         imm = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OPC_STORE:          imm = {{21{ir_q[31]}}, ir_q[30:25], ir_q[11:7]};
      default:            imm = {{21{ir_q[31]}}, ir_q[30:20]};
    endcase
  end

  // Legality and register-usage decode; byte/half accesses are illegal.
  always_comb begin
    legal    = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    uses_rd  = 1'b0;
    is_sys   = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        legal   = 1'b1;
        uses_rd = 1'b1;
      end
      OPC_JALR: begin
        legal    = (f3 == 3'b000);
        uses_rs1 = 1'b1;
        uses_rd  = 1'b1;
      end
      OPC_BRANCH: begin
        legal    = (f3 != 3'b010) && (f3 != 3'b011);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        legal    = (f3 == F3_LW);
        uses_rs1 = 1'b1;
        uses_rd  = 1'b1;
      end
      OPC_STORE: begin
        legal    = (f3 == F3_SW);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1;
        uses_rd  = 1'b1;
        if (f3 == F3_SLL)     legal = (f7 == F7_BASE);
        else if (f3 == F3_SR) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else                  legal = 1'b1;
      end
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        uses_rd  = 1'b1;
        legal    = (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == F3_ADD || f3 == F3_SR));
      end
      OPC_FENCE: legal = (f3 == 3'b000);
      OPC_SYSTEM: begin
        is_sys = (ir_q == INST_ECALL) || (ir_q == INST_EBREAK);
        legal  = is_sys;
      end
      default: legal = 1'b0;
    endcase
  end

  assign reg_bad = (uses_rs1 && 32'(rs1) >= REG_COUNT) ||
                   (uses_rs2 && 32'(rs2) >= REG_COUNT) ||
                   (uses_rd  && 32'(rd)  >= REG_COUNT);

  // ALU operation select; SUB only exists in register-register form.
  always_comb begin
    case (f3)
      F3_ADD:  alu_op = (opc == OPC_OP && f7[5]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = f7[5] ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  assign alu_b    = (opc == OPC_OP) ? rs2_val : imm;
  assign alu_res  = alu_f(alu_op, rs1_val, alu_b);
  assign addr_sum = rs1_val + imm;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_imm   = pc_q + imm;
  assign jalr_tgt = addr_sum & ~32'h1;
  assign br_taken = br_f(f3, rs1_val, rs2_val);

  // Next-state and datapath-register computation for every FSM state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    next_pc_d   = next_pc_q;
    wb_data_d   = wb_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    cause_d     = cause_q;
    halt_req    = 1'b0;
    halt_code   = HALT_NONE;
    case (state_q)
      ST_FETCH: begin
        // Coming out of reset the request has not been raised yet.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else if (mem.mem_ready) begin
          ir_d      = mem.mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!legal || reg_bad) begin
          halt_req  = 1'b1;
          halt_code = HALT_ILLEGAL;
        end else if (is_sys) begin
          halt_req  = 1'b1;
          halt_code = HALT_ECALL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        next_pc_d = pc_plus4;
        case (opc)
          OPC_BRANCH: begin
            // A taken branch to a half-word address would fetch misaligned.
            if (br_taken && pc_imm[1]) begin
              halt_req  = 1'b1;
              halt_code = HALT_MISALIGN;
            end else begin
              pc_d       = br_taken ? pc_imm : pc_plus4;
              mem_addr_d = br_taken ? pc_imm : pc_plus4;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              state_d    = ST_FETCH;
            end
          end
          OPC_LOAD, OPC_STORE: begin
            if (addr_sum[1:0] != 2'b00) begin
              halt_req  = 1'b1;
              halt_code = HALT_MISALIGN;
            end else begin
              mem_req_d  = 1'b1;
              mem_we_d   = (opc == OPC_STORE);
              mem_addr_d = addr_sum;
              if (opc == OPC_STORE) mem_wdata_d = rs2_val;
              state_d    = ST_MEM;
            end
          end
          OPC_JAL, OPC_JALR: begin
            if ((opc == OPC_JAL) ? pc_imm[1] : jalr_tgt[1]) begin
              halt_req  = 1'b1;
              halt_code = HALT_MISALIGN;
            end else begin
              next_pc_d = (opc == OPC_JAL) ? pc_imm : jalr_tgt;
              wb_data_d = pc_plus4;
              state_d   = ST_WB;
            end
          end
          OPC_LUI: begin
            wb_data_d = imm;
            state_d   = ST_WB;
          end
          OPC_AUIPC: begin
            wb_data_d = pc_imm;
            state_d   = ST_WB;
          end
          default: begin
            wb_data_d = alu_res;
            state_d   = ST_WB;
          end
        endcase
      end
      ST_MEM: begin
        if (mem.mem_ready) begin
          if (mem_we_q) begin
            pc_d       = pc_plus4;
            mem_addr_d = pc_plus4;
            mem_we_d   = 1'b0;
            state_d    = ST_FETCH;
          end else begin
            wb_data_d = mem.mem_rdata;
            next_pc_d = pc_plus4;
            mem_req_d = 1'b0;
            state_d   = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d       = next_pc_q;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = next_pc_q;
        state_d    = ST_FETCH;
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
    if (halt_req) begin
      state_d   = ST_HALT;
      halted_d  = 1'b1;
      cause_d   = halt_code;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
    end
  end

  // FSM state and all registered outputs; reset abandons any request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= INST_NOP;
      next_pc_q   <= RESET_PC;
      wb_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= RESET_PC;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      cause_q     <= HALT_NONE;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      next_pc_q   <= next_pc_d;
      wb_data_q   <= wb_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
      cause_q     <= cause_d;
    end
  end

  // A store retires on its accepted write, so retire depends on mem_ready.
  assign retire = (state_q == ST_WB) ||
                  (state_q == ST_EXEC && opc == OPC_BRANCH && !halt_req) ||
                  (state_q == ST_MEM && mem_we_q && mem.mem_ready);

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign halted        = halted_q;
  assign halt_cause    = cause_q;
  assign debug_pc      = pc_q;
  assign debug_inst    = ir_q;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: an RV32I core running a short
// program against a zero/wait-state memory model, plus an RV32E core that
// must reject a high register index.
module tb_riscv_multicycle_core;

  logic clk;
  logic rst_n;
  logic ready_en;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic        retire_a, halted_a, retire_b, halted_b;
  logic [1:0]  cause_a, cause_b;
  logic [31:0] dpc_a, dinst_a, dpc_b, dinst_b;

  logic [31:0] rom_a [0:63];
  logic [31:0] ram_a [0:63];
  logic [63:0] ram_v;
  logic [31:0] rom_b [0:63];
  logic [31:0] jalr_inst;
  logic [5:0]  ia;

  riscv_multicycle_core_if bus_a ();
  riscv_multicycle_core_if bus_b ();

  riscv_multicycle_core #(.RESET_PC(32'h0), .REG_COUNT(32)) dut_a (
    .clk        (clk),
    .reset      (rst_n),
    .mem        (bus_a),
    .retire     (retire_a),
    .halted     (halted_a),
    .halt_cause (cause_a),
    .debug_pc   (dpc_a),
    .debug_inst (dinst_a)
  );

  riscv_multicycle_core #(.RESET_PC(32'h0), .REG_COUNT(16)) dut_b (
    .clk        (clk),
    .reset      (rst_n),
    .mem        (bus_b),
    .retire     (retire_b),
    .halted     (halted_b),
    .halt_cause (cause_b),
    .debug_pc   (dpc_b),
    .debug_inst (dinst_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory A: program image plus an overlay of stored words.
  assign ia              = bus_a.mem_addr[7:2];
  assign bus_a.mem_ready = ready_en;
  assign bus_a.mem_rdata = ram_v[ia] ? ram_a[ia] : rom_a[ia];
  assign bus_b.mem_ready = 1'b1;
  assign bus_b.mem_rdata = rom_b[bus_b.mem_addr[7:2]];

  always @(posedge clk) begin
    if (!rst_n) ram_v <= '0;
    else if (bus_a.mem_req && bus_a.mem_we && ready_en) begin
      ram_v[ia] <= 1'b1;
      ram_a[ia] <= bus_a.mem_wdata;
    end
  end

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'b1100011};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    ready_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rom_a[i] = 32'h0000_0013;
      rom_b[i] = 32'h0000_0013;
    end
    jalr_inst = enc_i(3, 5, 0, 1, 7'b1100111);
    rom_a[0]  = enc_i(5, 0, 0, 1, 7'b0010011);     // addi x1,x0,5
    rom_a[1]  = enc_i(-3, 1, 0, 2, 7'b0010011);    // addi x2,x1,-3
    rom_a[2]  = enc_s(8, 2, 0);                    // sw x2,8(x0)
    rom_a[3]  = enc_i(8, 0, 2, 3, 7'b0000011);     // lw x3,8(x0)
    rom_a[4]  = enc_s(12, 3, 0);                   // sw x3,12(x0)
    rom_a[5]  = enc_i(-1, 0, 0, 1, 7'b0010011);    // addi x1,x0,-1
    rom_a[6]  = enc_i(1, 0, 0, 4, 7'b0010011);     // addi x4,x0,1
    rom_a[7]  = enc_b(12, 4, 1, 4);                // blt x1,x4,+12
    rom_a[10] = enc_b(12, 4, 1, 6);                // bltu x1,x4,+12
    rom_a[11] = enc_i(256, 0, 0, 5, 7'b0010011);   // addi x5,x0,0x100
    rom_a[12] = jalr_inst;                         // jalr x1,3(x5)
    rom_b[0]  = enc_i(1, 0, 0, 20, 7'b0010011);    // addi x20,x0,1

    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(bus_a.mem_req), 32'h0);
    check("rst_we", 32'(bus_a.mem_we), 32'h0);
    check("rst_addr", bus_a.mem_addr, 32'h0);
    check("rst_wdata", bus_a.mem_wdata, 32'h0);
    check("rst_retire", 32'(retire_a), 32'h0);
    check("rst_halted", 32'(halted_a), 32'h0);
    check("rst_cause", 32'(cause_a), 32'h0);
    check("rst_dpc", dpc_a, 32'h0);
    check("rst_dinst", dinst_a, 32'h0000_0013);

    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    tick_to(1);
    check("c1_req", 32'(bus_a.mem_req), 32'h1);
    check("c1_addr", bus_a.mem_addr, 32'h0);
    check("c1_we", 32'(bus_a.mem_we), 32'h0);
    tick_to(2);
    check("e_c2_halted", 32'(halted_b), 32'h0);
    tick_to(3);
    check("c3_retire", 32'(retire_a), 32'h0);
    check("e_halted", 32'(halted_b), 32'h1);
    check("e_cause", 32'(cause_b), 32'h1);
    check("e_dpc", dpc_b, 32'h0);
    check("e_req", 32'(bus_b.mem_req), 32'h0);
    tick_to(4);
    check("c4_retire", 32'(retire_a), 32'h1);
    check("e_retire", 32'(retire_b), 32'h0);
    tick_to(5);
    check("c5_retire", 32'(retire_a), 32'h0);
    check("c5_addr", bus_a.mem_addr, 32'h4);
    tick_to(7);
    check("c7_retire", 32'(retire_a), 32'h0);
    tick_to(8);
    check("c8_retire", 32'(retire_a), 32'h1);

    // Hold off the fetch of the store for three cycles.
    ready_en = 1'b0;
    for (int k = 9; k <= 12; k++) begin
      tick_to(k);
      check("wait_req", 32'(bus_a.mem_req), 32'h1);
      check("wait_addr", bus_a.mem_addr, 32'h8);
      check("wait_we", 32'(bus_a.mem_we), 32'h0);
      check("wait_retire", 32'(retire_a), 32'h0);
    end
    ready_en = 1'b1;
    tick_to(14);
    check("c14_retire", 32'(retire_a), 32'h0);
    tick_to(15);
    check("sw_retire", 32'(retire_a), 32'h1);
    check("sw_we", 32'(bus_a.mem_we), 32'h1);
    check("sw_addr", bus_a.mem_addr, 32'h8);
    check("sw_x2", bus_a.mem_wdata, 32'h2);
    tick_to(16);
    check("c16_retire", 32'(retire_a), 32'h0);
    check("c16_addr", bus_a.mem_addr, 32'hC);
    tick_to(19);
    check("lw_c19_retire", 32'(retire_a), 32'h0);
    check("lw_addr", bus_a.mem_addr, 32'h8);
    tick_to(20);
    check("lw_retire", 32'(retire_a), 32'h1);
    tick_to(24);
    check("sw2_retire", 32'(retire_a), 32'h1);
    check("sw2_addr", bus_a.mem_addr, 32'hC);
    check("sw2_x3", bus_a.mem_wdata, 32'h2);

    tick_to(33);
    check("blt_fetch", bus_a.mem_addr, 32'h1C);
    tick_to(35);
    check("blt_retire", 32'(retire_a), 32'h1);
    tick_to(36);
    check("blt_taken", bus_a.mem_addr, 32'h28);
    check("blt_req", 32'(bus_a.mem_req), 32'h1);
    tick_to(38);
    check("bltu_retire", 32'(retire_a), 32'h1);
    tick_to(39);
    check("bltu_ntaken", bus_a.mem_addr, 32'h2C);
    tick_to(43);
    check("jalr_fetch", bus_a.mem_addr, 32'h30);
    tick_to(45);
    check("jalr_retire", 32'(retire_a), 32'h0);
    check("jalr_prehalt", 32'(halted_a), 32'h0);
    tick_to(46);
    check("jalr_halted", 32'(halted_a), 32'h1);
    check("jalr_cause", 32'(cause_a), 32'h2);
    check("jalr_dpc", dpc_a, 32'h30);
    check("jalr_dinst", dinst_a, jalr_inst);
    check("jalr_x1", dut_a.u_rf.regs_q[1], 32'hFFFF_FFFF);
    for (int k = 0; k < 6; k++) begin
      check("halt_req", 32'(bus_a.mem_req), 32'h0);
      check("halt_retire", 32'(retire_a), 32'h0);
      tick();
    end

    // Reset in the middle of a stalled fetch.
    ready_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    tick_to(2);
    check("rf_req", 32'(bus_a.mem_req), 32'h1);
    check("rf_addr", bus_a.mem_addr, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rf_async_drop", 32'(bus_a.mem_req), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    ready_en = 1'b1;
    cyc      = 0;
    tick_to(1);
    check("rf_refetch_req", 32'(bus_a.mem_req), 32'h1);
    check("rf_refetch_addr", bus_a.mem_addr, 32'h0);
    check("rf_halted", 32'(halted_a), 32'h0);
    tick_to(4);
    check("rf_retire", 32'(retire_a), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
